// File: rtl/next_pc_sequencer.sv
// next_pc_sequencer
//   Multicycle next-PC controller for the RV32I core. Owns the PC register and
//   performs sequential advance, JAL / taken-branch (PC-relative) and JALR
//   (register-relative) redirects through a RESOLVE -> REDIRECT sequence that
//   emits a flush and, for jumps, a link-register write request. A misaligned
//   target parks the sequencer in TRAP until reset.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   instr_valid_i  in   decoded instruction present (single-cycle pulse)
//   jal_i          in   instruction is JAL
//   jalr_i         in   instruction is JALR
//   branch_i       in   instruction is a conditional branch
//   branch_taken_i in   comparator result, valid with branch_i
//   imm_i          in   sign-extended immediate
//   rs1_data_i     in   rs1 operand for JALR
//   stall_i        in   hazard stall; freezes FETCH and RESOLVE
//   pc_o           out  current PC (registered)
//   pc_update_o    out  pulse on the first cycle pc_o shows a new value
//   flush_o        out  pulse, discard fetched/decoded instruction
//   link_we_o      out  pulse, write link_o to rd (JAL/JALR only)
//   link_o         out  return address (PC of jump + 4)
//   busy_o         out  high whenever not in FETCH
//   misalign_o     out  sticky misaligned-target error
module next_pc_sequencer #(
  parameter int unsigned    NBits    = 32,
  parameter logic [NBits-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid_i,
  input  logic             jal_i,
  input  logic             jalr_i,
  input  logic             branch_i,
  input  logic             branch_taken_i,
  input  logic [NBits-1:0] imm_i,
  input  logic [NBits-1:0] rs1_data_i,
  input  logic             stall_i,
  output logic [NBits-1:0] pc_o,
  output logic             pc_update_o,
  output logic             flush_o,
  output logic             link_we_o,
  output logic [NBits-1:0] link_o,
  output logic             busy_o,
  output logic             misalign_o
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    RESOLVE  = 2'd1,
    REDIRECT = 2'd2,
    TRAP     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [NBits-1:0] pc_q, pc_d;
  logic [NBits-1:0] link_q, link_d;
  logic [NBits-1:0] target_q, target_d;
  logic             is_link_q, is_link_d;
  logic             pc_update_q, pc_update_d;

  logic [NBits-1:0] pc_plus4;
  logic [NBits-1:0] pc_rel_tgt;
  logic [NBits-1:0] jalr_sum;
  logic [NBits-1:0] jalr_tgt;

  assign pc_plus4   = pc_q + NBits'(4);
  assign pc_rel_tgt = pc_q + imm_i;
  assign jalr_sum   = rs1_data_i + imm_i;
  assign jalr_tgt   = {jalr_sum[NBits-1:1], 1'b0};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    link_d      = link_q;
    target_d    = target_q;
    is_link_d   = is_link_q;
    pc_update_d = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (!stall_i && instr_valid_i) begin
          if (jalr_i || jal_i || (branch_i && branch_taken_i)) begin
            // Priority jalr > jal > branch.
            target_d  = jalr_i ? jalr_tgt : pc_rel_tgt;
            is_link_d = jalr_i || jal_i;
            link_d    = pc_plus4;
            state_d   = RESOLVE;
          end else begin
            pc_d        = pc_plus4;
            pc_update_d = 1'b1;
          end
        end
      end
      RESOLVE: begin
        if (!stall_i) begin
          if (target_q[1:0] != 2'b00) begin
            state_d = TRAP;
          end else begin
            pc_d        = target_q;
            pc_update_d = 1'b1;
            state_d     = REDIRECT;
          end
        end
      end
      REDIRECT: state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      link_q      <= '0;
      target_q    <= '0;
      is_link_q   <= 1'b0;
      pc_update_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      link_q      <= link_d;
      target_q    <= target_d;
      is_link_q   <= is_link_d;
      pc_update_q <= pc_update_d;
    end
  end

  // Pulses are derived from registered state so they line up with pc_o.
  assign pc_o        = pc_q;
  assign link_o      = link_q;
  assign pc_update_o = pc_update_q;
  assign flush_o     = (state_q == REDIRECT);
  assign link_we_o   = (state_q == REDIRECT) && is_link_q;
  assign busy_o      = (state_q != FETCH);
  assign misalign_o  = (state_q == TRAP);

endmodule

// File: tb/tb_next_pc_sequencer.sv
module tb_next_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        instr_valid_i, jal_i, jalr_i, branch_i, branch_taken_i, stall_i;
  logic [31:0] imm_i, rs1_data_i;
  logic [31:0] pc_o, link_o;
  logic        pc_update_o, flush_o, link_we_o, busy_o, misalign_o;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  localparam logic [31:0] RPC = 32'h0040_0000;

  next_pc_sequencer #(.NBits(32), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .instr_valid_i(instr_valid_i), .jal_i(jal_i), .jalr_i(jalr_i),
    .branch_i(branch_i), .branch_taken_i(branch_taken_i),
    .imm_i(imm_i), .rs1_data_i(rs1_data_i), .stall_i(stall_i),
    .pc_o(pc_o), .pc_update_o(pc_update_o), .flush_o(flush_o),
    .link_we_o(link_we_o), .link_o(link_o), .busy_o(busy_o),
    .misalign_o(misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    instr_valid_i = 1'b0; jal_i = 1'b0; jalr_i = 1'b0; branch_i = 1'b0;
    branch_taken_i = 1'b0; stall_i = 1'b0; imm_i = '0; rs1_data_i = '0;
  endtask

  // {pc_update, flush, link_we, busy, misalign} packed for compact checks
  task automatic test_reset();
    clr_in();
    reset = 1'b1;
    #3;
    total_cnt++;
    if (pc_o !== RPC || link_o !== 32'h0 ||
        {pc_update_o, flush_o, link_we_o, busy_o, misalign_o} !== 5'b0) begin
      $display("FAIL reset_state: pc=%h link=%h flags=%b required pc=%h link=0 flags=00000",
               pc_o, link_o, {pc_update_o, flush_o, link_we_o, busy_o, misalign_o}, RPC);
    end else pass_cnt++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = RPC;
    instr_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      total_cnt++;
      if (pc_o !== exp_pc || {pc_update_o, flush_o, busy_o} !== 3'b100) begin
        $display("FAIL seq_%0d: pc=%h upd/flush/busy=%b required pc=%h 100",
                 i, pc_o, {pc_update_o, flush_o, busy_o}, exp_pc);
      end else pass_cnt++;
    end
    instr_valid_i = 1'b0;
    tick();
    total_cnt++;
    if (pc_o !== 32'h0040_0010 || pc_update_o !== 1'b0) begin
      $display("FAIL seq_idle: pc=%h upd=%b required pc=00400010 upd=0", pc_o, pc_update_o);
    end else pass_cnt++;
  endtask

  task automatic test_jal();
    instr_valid_i = 1'b1; jal_i = 1'b1; imm_i = 32'h20;
    tick();
    clr_in();
    total_cnt++;
    if (pc_o !== 32'h0040_0010 || link_o !== 32'h0040_0014 ||
        {pc_update_o, flush_o, link_we_o, busy_o} !== 4'b0001) begin
      $display("FAIL jal_resolve: pc=%h link=%h flags=%b required pc=00400010 link=00400014 flags=0001",
               pc_o, link_o, {pc_update_o, flush_o, link_we_o, busy_o});
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (pc_o !== 32'h0040_0030 || link_o !== 32'h0040_0014 ||
        {pc_update_o, flush_o, link_we_o, busy_o} !== 4'b1111) begin
      $display("FAIL jal_redirect: pc=%h link=%h flags=%b required pc=00400030 link=00400014 flags=1111",
               pc_o, link_o, {pc_update_o, flush_o, link_we_o, busy_o});
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (pc_o !== 32'h0040_0030 || {pc_update_o, flush_o, link_we_o, busy_o} !== 4'b0000) begin
      $display("FAIL jal_done: pc=%h flags=%b required pc=00400030 flags=0000",
               pc_o, {pc_update_o, flush_o, link_we_o, busy_o});
    end else pass_cnt++;
  endtask

  // jal and taken-branch flags also set: jalr must win
  task automatic test_jalr_priority();
    instr_valid_i = 1'b1; jalr_i = 1'b1; jal_i = 1'b1; branch_i = 1'b1;
    branch_taken_i = 1'b1; imm_i = 32'hFFFF_FFFE; rs1_data_i = 32'h1000_0003;
    tick();
    clr_in();
    total_cnt++;
    if (link_o !== 32'h0040_0034 || busy_o !== 1'b1) begin
      $display("FAIL jalr_resolve: link=%h busy=%b required link=00400034 busy=1", link_o, busy_o);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (pc_o !== 32'h1000_0000 || {pc_update_o, flush_o, link_we_o, busy_o} !== 4'b1111) begin
      $display("FAIL jalr_redirect: pc=%h flags=%b required pc=10000000 flags=1111",
               pc_o, {pc_update_o, flush_o, link_we_o, busy_o});
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_branch();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    instr_valid_i = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (pc_o !== 32'h0040_0008) begin
      $display("FAIL br_setup: pc=%h required 00400008", pc_o);
    end else pass_cnt++;
    branch_i = 1'b1; branch_taken_i = 1'b1; imm_i = 32'hFFFF_FFF8;
    tick();
    clr_in();
    tick();
    total_cnt++;
    if (pc_o !== 32'h0040_0000 || link_o !== 32'h0040_000C ||
        {pc_update_o, flush_o, link_we_o, busy_o} !== 4'b1101) begin
      $display("FAIL br_taken: pc=%h link=%h flags=%b required pc=00400000 link=0040000c flags=1101",
               pc_o, link_o, {pc_update_o, flush_o, link_we_o, busy_o});
    end else pass_cnt++;
    tick();
    instr_valid_i = 1'b1; branch_i = 1'b1; branch_taken_i = 1'b0; imm_i = 32'h100;
    tick();
    clr_in();
    total_cnt++;
    if (pc_o !== 32'h0040_0004 || {pc_update_o, flush_o, link_we_o, busy_o} !== 4'b1000) begin
      $display("FAIL br_not_taken: pc=%h flags=%b required pc=00400004 flags=1000",
               pc_o, {pc_update_o, flush_o, link_we_o, busy_o});
    end else pass_cnt++;
  endtask

  task automatic test_stall();
    stall_i = 1'b1; instr_valid_i = 1'b1; jal_i = 1'b1; imm_i = 32'h100;
    tick();
    total_cnt++;
    if (pc_o !== 32'h0040_0004 || {pc_update_o, busy_o} !== 2'b00) begin
      $display("FAIL stall_fetch: pc=%h upd/busy=%b required pc=00400004 00", pc_o, {pc_update_o, busy_o});
    end else pass_cnt++;
    stall_i = 1'b0;
    tick();
    clr_in();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (pc_o !== 32'h0040_0004 || {pc_update_o, flush_o, link_we_o, busy_o} !== 4'b0001) begin
        $display("FAIL stall_resolve_%0d: pc=%h flags=%b required pc=00400004 flags=0001",
                 i, pc_o, {pc_update_o, flush_o, link_we_o, busy_o});
      end else pass_cnt++;
    end
    stall_i = 1'b0;
    tick();
    total_cnt++;
    if (pc_o !== 32'h0040_0104 || link_o !== 32'h0040_0008 ||
        {pc_update_o, flush_o, link_we_o, busy_o} !== 4'b1111) begin
      $display("FAIL stall_redirect: pc=%h link=%h flags=%b required pc=00400104 link=00400008 flags=1111",
               pc_o, link_o, {pc_update_o, flush_o, link_we_o, busy_o});
    end else pass_cnt++;
    stall_i = 1'b1;
    tick();
    total_cnt++;
    if (pc_o !== 32'h0040_0104 || {pc_update_o, flush_o, link_we_o, busy_o} !== 4'b0000) begin
      $display("FAIL stall_in_redirect: pc=%h flags=%b required pc=00400104 flags=0000",
               pc_o, {pc_update_o, flush_o, link_we_o, busy_o});
    end else pass_cnt++;
    stall_i = 1'b0;
  endtask

  task automatic test_trap();
    instr_valid_i = 1'b1; jalr_i = 1'b1; rs1_data_i = 32'h0040_0002; imm_i = '0;
    tick();
    clr_in();
    tick();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (pc_o !== 32'h0040_0104 || link_o !== 32'h0040_0108 ||
          {pc_update_o, flush_o, link_we_o, busy_o, misalign_o} !== 5'b00011) begin
        $display("FAIL trap_%0d: pc=%h link=%h flags=%b required pc=00400104 link=00400108 flags=00011",
                 i, pc_o, link_o, {pc_update_o, flush_o, link_we_o, busy_o, misalign_o});
      end else pass_cnt++;
      instr_valid_i = 1'b1;
      tick();
    end
    clr_in();
    #3;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (pc_o !== RPC || link_o !== 32'h0 || {busy_o, misalign_o} !== 2'b00) begin
      $display("FAIL trap_reset: pc=%h link=%h busy/mis=%b required pc=%h link=0 00",
               pc_o, link_o, {busy_o, misalign_o}, RPC);
    end else pass_cnt++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_resolve();
    instr_valid_i = 1'b1; jal_i = 1'b1; imm_i = 32'h40;
    tick();
    clr_in();
    total_cnt++;
    if (busy_o !== 1'b1 || link_o !== 32'h0040_0004) begin
      $display("FAIL mid_setup: busy=%b link=%h required busy=1 link=00400004", busy_o, link_o);
    end else pass_cnt++;
    #3;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (pc_o !== RPC || link_o !== 32'h0 ||
        {pc_update_o, flush_o, link_we_o, busy_o, misalign_o} !== 5'b0) begin
      $display("FAIL mid_async_reset: pc=%h link=%h flags=%b required pc=%h link=0 flags=00000",
               pc_o, link_o, {pc_update_o, flush_o, link_we_o, busy_o, misalign_o}, RPC);
    end else pass_cnt++;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++;
      if (pc_o !== RPC || {pc_update_o, flush_o, link_we_o, busy_o} !== 4'b0000) begin
        $display("FAIL mid_no_pending_%0d: pc=%h flags=%b required pc=%h flags=0000",
                 i, pc_o, {pc_update_o, flush_o, link_we_o, busy_o}, RPC);
      end else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    instr_valid_i = 1'b1; jalr_i = 1'b1; rs1_data_i = 32'hFFFF_FFFC; imm_i = '0;
    tick();
    clr_in();
    tick();
    total_cnt++;
    if (pc_o !== 32'hFFFF_FFFC || pc_update_o !== 1'b1) begin
      $display("FAIL wrap_setup: pc=%h upd=%b required pc=fffffffc upd=1", pc_o, pc_update_o);
    end else pass_cnt++;
    tick();
    instr_valid_i = 1'b1;
    tick();
    clr_in();
    total_cnt++;
    if (pc_o !== 32'h0 || {pc_update_o, busy_o} !== 2'b10) begin
      $display("FAIL wrap: pc=%h upd/busy=%b required pc=00000000 10", pc_o, {pc_update_o, busy_o});
    end else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    test_reset();
    test_sequential();
    test_jal();
    test_jalr_priority();
    test_branch();
    test_stall();
    test_trap();
    test_reset_mid_resolve();
    test_wrap();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
